// File: rtl/meduram_pkg.sv
// Definitions shared across the meduram read path (accounter and read_selector):
// bank-select width helper and the default debug counter width.
package meduram_pkg;

    localparam int CNT_WIDTH_DEFAULT = 16;

    // Bank index bits plus an optional collision flag in the MSB.
    function automatic int select_width(input int nb_wragent, input int write_collision);
        return ((nb_wragent == 1) ? 1 : $clog2(nb_wragent)) + write_collision;
    endfunction

endpackage

// File: rtl/select_pipe.sv
// Delay line carrying {valid, select} alongside the RAM read latency.
// Only the valid bits are reset; select payload is captured on valid only.
module select_pipe #(
    parameter int SELECT_WIDTH = 2,
    parameter int DEPTH        = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    valid_i,
    input  logic [SELECT_WIDTH-1:0] select_i,
    output logic                    valid_o,
    output logic [SELECT_WIDTH-1:0] select_o
);

    logic [DEPTH-1:0]        valid_q;
    logic [SELECT_WIDTH-1:0] select_q   [DEPTH];
    logic [DEPTH-1:0]        valid_d;
    logic [SELECT_WIDTH-1:0] select_d   [DEPTH];

    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        valid_d     = '0;
        select_d[0] = select_i;
        valid_d[0]  = valid_i;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i]  = valid_q[i-1];
            select_d[i] = select_q[i-1];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the select payload is deliberately not reset; an idle stage's select is never used.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i]) begin
                select_q[i] <= select_d[i];
            end
        end
    end

    assign valid_o  = valid_q[DEPTH-1];
    assign select_o = select_q[DEPTH-1];

endmodule

// File: rtl/read_selector.sv
// Read-port data selector: delays the accounter's bank_select by the RAM latency,
// muxes the matching bank and counts collided reads. Optional MEDURAM_RDSEL_OUTREG_EN registers the outputs.
module read_selector
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int NB_WRAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int RAM_LATENCY     = 1,
    parameter int SELECT_WIDTH    = select_width(NB_WRAGENT, WRITE_COLLISION),
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           rden,
    input  logic [SELECT_WIDTH-1:0]        bank_select,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
    output logic                           rdvalid,
    output logic [DATA_WIDTH-1:0]          rddata,
    output logic                           rdcollision,
    input  logic                           cnt_clear,
    output logic [CNT_WIDTH-1:0]           collision_cnt
);

    localparam int IDX_WIDTH = SELECT_WIDTH - WRITE_COLLISION;

    if (RAM_LATENCY < 1 || ADDR_WIDTH < 1 ||
        SELECT_WIDTH != select_width(NB_WRAGENT, WRITE_COLLISION)) begin : g_bad_cfg
        $error("read_selector: unsupported parameter combination");
    end

    logic                    pipe_valid;
    logic [SELECT_WIDTH-1:0] pipe_select;
    logic [IDX_WIDTH-1:0]    bank_idx;
    logic                    sel_coll;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_d;
    logic                    out_coll_d;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    cnt_d;

    select_pipe #(
        .SELECT_WIDTH (SELECT_WIDTH),
        .DEPTH        (RAM_LATENCY)
    ) u_select_pipe (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .valid_i  (rden),
        .select_i (bank_select),
        .valid_o  (pipe_valid),
        .select_o (pipe_select)
    );

    assign bank_idx = pipe_select[IDX_WIDTH-1:0];

    // Indices past the last bank fall through to zero; a single bank ignores the index.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            if (NB_WRAGENT == 1 || int'(bank_idx) == i) begin
                mux_data = bank_rddata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    if (WRITE_COLLISION != 0) begin : g_coll
        assign sel_coll = pipe_select[SELECT_WIDTH-1];
    end else begin : g_no_coll
        assign sel_coll = 1'b0;
    end

    assign out_valid_d = pipe_valid;
    assign out_data_d  = pipe_valid ? mux_data : '0;
    assign out_coll_d  = pipe_valid & sel_coll;

`ifdef MEDURAM_RDSEL_OUTREG_EN
    logic                  rdvalid_q;
    logic [DATA_WIDTH-1:0] rddata_q;
    logic                  rdcollision_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdvalid_q     <= 1'b0;
            rddata_q      <= '0;
            rdcollision_q <= 1'b0;
        end else begin
            rdvalid_q     <= out_valid_d;
            rddata_q      <= out_data_d;
            rdcollision_q <= out_coll_d;
        end
    end

    assign rdvalid     = rdvalid_q;
    assign rddata      = rddata_q;
    assign rdcollision = rdcollision_q;
`else
    assign rdvalid     = out_valid_d;
    assign rddata      = out_data_d;
    assign rdcollision = out_coll_d;
`endif

    // Clear takes priority over a coincident increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (rdvalid && rdcollision && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign collision_cnt = cnt_q;

endmodule
